// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Arbitrates instruction-fetch and data ports onto a single-ported
//            backing memory. One pending slot per port, data has priority,
//            all outputs registered.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int WORD_SIZE = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   // instruction port
   input  logic                 i_read,
   input  logic [WORD_SIZE-1:0] i_addr,
   output logic [WORD_SIZE-1:0] i_data,
   output logic                 i_valid,
   // data port
   input  logic                 d_read,
   input  logic                 d_write,
   input  logic [WORD_SIZE-1:0] d_addr,
   input  logic [WORD_SIZE-1:0] d_wdata,
   output logic [WORD_SIZE-1:0] d_rdata,
   output logic                 d_valid,
   // backing memory
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [WORD_SIZE-1:0] mem_addr,
   output logic [WORD_SIZE-1:0] mem_wdata,
   input  logic [WORD_SIZE-1:0] mem_rdata,
   input  logic                 mem_ack,
   // status
   output logic                 busy,
   output logic                 overrun,
   output logic [WORD_SIZE-1:0] txn_count
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_I_WAIT = 2'd1,
      S_D_WAIT = 2'd2
   } state_t;

   localparam logic [WORD_SIZE-1:0] ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

   state_t state, state_nx;

   // pending slots; a slot stays pending until its transaction is acked
   logic                 i_pend, i_pend_nx;
   logic [WORD_SIZE-1:0] i_slot_addr, i_slot_addr_nx;
   logic                 d_pend, d_pend_nx;
   logic [WORD_SIZE-1:0] d_slot_addr, d_slot_addr_nx;
   logic [WORD_SIZE-1:0] d_slot_wdata, d_slot_wdata_nx;
   logic                 d_slot_we, d_slot_we_nx;

   // next values of the registered outputs
   logic                 mem_req_nx, mem_we_nx;
   logic [WORD_SIZE-1:0] mem_addr_nx, mem_wdata_nx;
   logic [WORD_SIZE-1:0] i_data_nx, d_rdata_nx, txn_count_nx;
   logic                 i_valid_nx, d_valid_nx, overrun_nx, busy_nx;

   // State and all registered outputs; reset abandons any transaction in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         i_pend       <= 1'b0;
         i_slot_addr  <= '0;
         d_pend       <= 1'b0;
         d_slot_addr  <= '0;
         d_slot_wdata <= '0;
         d_slot_we    <= 1'b0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         i_data       <= '0;
         d_rdata      <= '0;
         i_valid      <= 1'b0;
         d_valid      <= 1'b0;
         overrun      <= 1'b0;
         busy         <= 1'b0;
         txn_count    <= '0;
      end else begin
         state        <= state_nx;
         i_pend       <= i_pend_nx;
         i_slot_addr  <= i_slot_addr_nx;
         d_pend       <= d_pend_nx;
         d_slot_addr  <= d_slot_addr_nx;
         d_slot_wdata <= d_slot_wdata_nx;
         d_slot_we    <= d_slot_we_nx;
         mem_req      <= mem_req_nx;
         mem_we       <= mem_we_nx;
         mem_addr     <= mem_addr_nx;
         mem_wdata    <= mem_wdata_nx;
         i_data       <= i_data_nx;
         d_rdata      <= d_rdata_nx;
         i_valid      <= i_valid_nx;
         d_valid      <= d_valid_nx;
         overrun      <= overrun_nx;
         busy         <= busy_nx;
         txn_count    <= txn_count_nx;
      end
   end

   // Slot capture, grant selection and completion handling
   always_comb begin
      state_nx        = state;
      i_pend_nx       = i_pend;
      i_slot_addr_nx  = i_slot_addr;
      d_pend_nx       = d_pend;
      d_slot_addr_nx  = d_slot_addr;
      d_slot_wdata_nx = d_slot_wdata;
      d_slot_we_nx    = d_slot_we;
      mem_req_nx      = mem_req;
      mem_we_nx       = mem_we;
      mem_addr_nx     = mem_addr;
      mem_wdata_nx    = mem_wdata;
      i_data_nx       = i_data;
      d_rdata_nx      = d_rdata;
      i_valid_nx      = 1'b0;
      d_valid_nx      = 1'b0;
      overrun_nx      = overrun;
      txn_count_nx    = txn_count;

      // A request on an occupied slot is dropped; the slot is still occupied
      // on the edge its ack arrives, so that case counts as an overrun too.
      if (i_read) begin
         if (i_pend) begin
            overrun_nx = 1'b1;
         end else begin
            i_pend_nx      = 1'b1;
            i_slot_addr_nx = i_addr;
         end
      end

      // Simultaneous read and write is captured as a write.
      if (d_read || d_write) begin
         if (d_pend) begin
            overrun_nx = 1'b1;
         end else begin
            d_pend_nx       = 1'b1;
            d_slot_addr_nx  = d_addr;
            d_slot_wdata_nx = d_wdata;
            d_slot_we_nx    = d_write;
         end
      end

      case (state)
         S_IDLE: begin
            // Grants only look at already-registered slots, which leaves
            // mem_req low for at least one cycle between transactions.
            if (d_pend) begin
               state_nx     = S_D_WAIT;
               mem_req_nx   = 1'b1;
               mem_we_nx    = d_slot_we;
               mem_addr_nx  = d_slot_addr;
               mem_wdata_nx = d_slot_wdata;
            end else if (i_pend) begin
               state_nx     = S_I_WAIT;
               mem_req_nx   = 1'b1;
               mem_we_nx    = 1'b0;
               mem_addr_nx  = i_slot_addr;
               mem_wdata_nx = '0;
            end
         end
         S_I_WAIT: begin
            if (mem_ack) begin
               i_data_nx    = mem_rdata;
               i_valid_nx   = 1'b1;
               i_pend_nx    = 1'b0;
               mem_req_nx   = 1'b0;
               mem_we_nx    = 1'b0;
               txn_count_nx = txn_count + ONE;
               state_nx     = S_IDLE;
            end
         end
         S_D_WAIT: begin
            if (mem_ack) begin
               if (!d_slot_we) begin
                  d_rdata_nx = mem_rdata;
               end
               d_valid_nx   = 1'b1;
               d_pend_nx    = 1'b0;
               mem_req_nx   = 1'b0;
               mem_we_nx    = 1'b0;
               txn_count_nx = txn_count + ONE;
               state_nx     = S_IDLE;
            end
         end
         default: begin
            state_nx   = S_IDLE;
            mem_req_nx = 1'b0;
            mem_we_nx  = 1'b0;
         end
      endcase

      busy_nx = i_pend_nx | d_pend_nx | (state_nx != S_IDLE);
   end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 16, data and address width of every bus.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 i_read  input  1  instruction-fetch request pulse from datapath (readM1).
REQ-005 i_addr  input  WORD_SIZE  instruction address, valid with i_read.
REQ-006 i_data  output  WORD_SIZE  fetched instruction word.
REQ-007 i_valid  output  1  one-cycle pulse: i_data valid.
REQ-008 d_read  input  1  data-read request pulse (readM2).
REQ-009 d_write  input  1  data-write request pulse (writeM2).
REQ-010 d_addr  input  WORD_SIZE  data address, valid with d_read/d_write.
REQ-011 d_wdata  input  WORD_SIZE  write data, valid with d_write.
REQ-012 d_rdata  output  WORD_SIZE  data-read result.
REQ-013 d_valid  output  1  one-cycle pulse: data read returned or write completed.
REQ-014 mem_req  output  1  request to single-ported backing memory.
REQ-015 mem_we  output  1  1 = write, 0 = read; valid while mem_req.
REQ-016 mem_addr, mem_wdata  output  WORD_SIZE each  address/write data, valid while mem_req.
REQ-017 mem_rdata  input  WORD_SIZE  read data, valid in the cycle mem_ack=1.
REQ-018 mem_ack  input  1  one-cycle completion strobe from memory.
REQ-019 busy  output  1  1 while any request pending or in flight (stall to control unit).
REQ-020 overrun  output  1  sticky error: request arrived on a port already pending.
REQ-021 txn_count  output  WORD_SIZE  completed-transaction counter.

Function
REQ-022 Each port SHALL have one pending slot (pend flag, address, write data, we) loaded on the posedge where its request is high.
REQ-023 d_read and d_write both high SHALL be captured as a write; d_read ignored.
REQ-024 Request on a port whose slot is pending or in flight SHALL be dropped and SHALL set overrun (cleared only by reset).
REQ-025 FSM states: IDLE, I_WAIT, D_WAIT; all outputs registered.
REQ-026 IDLE: if data slot pending -> D_WAIT, else if instruction slot pending -> I_WAIT; data SHALL have priority.
REQ-027 On entering a WAIT state, mem_req=1 with that slot's addr/we/wdata; held stable until the cycle mem_ack=1 inclusive.
REQ-028 On mem_ack in WAIT: read -> capture mem_rdata into i_data/d_rdata; the port's valid SHALL be 1 in the following cycle only; slot cleared; mem_req=0 next cycle; state -> IDLE.
REQ-029 Write completion SHALL pulse d_valid identically; d_rdata unchanged.
REQ-030 After returning to IDLE, the next grant SHALL occur one cycle later (mem_req low at least one cycle between transactions).
REQ-031 mem_ack in IDLE SHALL be ignored.
REQ-032 Minimum latency: request at cycle 0 -> mem_req cycle 1 -> ack cycle 1 -> valid cycle 2.
REQ-033 A request on the other port during a WAIT SHALL be captured and served after the current transaction.
REQ-034 txn_count SHALL increment by 1 per mem_ack accepted, wrapping 0xFFFF -> 0x0000.
REQ-035 busy = either pend flag | state != IDLE, registered with state.

Reset
REQ-036 On reset: state IDLE, pend flags 0, mem_req 0, mem_we 0, i_valid 0, d_valid 0, overrun 0, txn_count 0, i_data/d_rdata/mem_addr/mem_wdata 0.
REQ-037 Reset during WAIT SHALL abandon the transaction; a mem_ack arriving later SHALL be ignored; reset SHALL override simultaneous requests.

Verification
REQ-038 i_read, i_addr=0x0010; memory acks same cycle as mem_req with 0xA5C3 -> i_valid at cycle 2, i_data=0xA5C3, txn_count=1.
REQ-039 i_read and d_write (addr 0x0020, data 0x1234) same cycle -> write issued first (mem_we=1), then fetch; d_valid before i_valid, txn_count=2.
REQ-040 d_read 0x0030, mem_ack delayed 5 cycles -> mem_req/mem_addr stable 5 cycles, busy=1 throughout, d_valid one cycle after ack.
REQ-041 Second i_read while first pending -> overrun=1, only one memory fetch, sticky until reset.
REQ-042 Reset in D_WAIT then late mem_ack -> no d_valid, txn_count=0, mem_req=0.
REQ-043 Preload txn_count to 0xFFFF via 65535 transactions, one more -> txn_count=0x0000.
